ft2232h_tx_scheduler: RTL and testbench

//   Shares one FT2232H sync-FIFO byte-write port between N frame producers (ADC capture channels).

---
 rtl/ft2232h_pkg.sv | 17 +
 rtl/ft2232h_tx_scheduler_rr_arbiter.sv | 45 ++++
 rtl/ft2232h_tx_scheduler.sv | 140 ++++++++++++++
 tb/tb_ft2232h_tx_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ft2232h_pkg.sv
// Shared types and helpers for the FT2232H frame transmit scheduler.
package ft2232h_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      CID  = 2'd2,
      PAY  = 2'd3
   } tx_state_t;

   localparam logic [7:0] HEADER_BYTE_DEF = 8'hFF;

   function automatic int frame_bytes(input int bits);
      return (bits + 7) / 8;
   endfunction

endpackage

// File: rtl/ft2232h_tx_scheduler_rr_arbiter.sv
// Round-robin requester pick with the rotating pointer held locally.
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] winner
);

   logic [IW-1:0] ptr;
   logic          found;

   function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int off);
      int s;
      s = int'(p) + off;
      return IW'(s % N);
   endfunction

   // Scan starts at the pointer so the last winner is checked last.
   always_comb begin
      gnt    = '0;
      winner = '0;
      found  = 1'b0;
      for (int off = 0; off < N; off++) begin
         if (!found && req[wrap_idx(ptr, off)]) begin
            found  = 1'b1;
            winner = wrap_idx(ptr, off);
         end
      end
      if (en && found) gnt[winner] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (en && found) begin
         ptr <= (winner == IW'(N - 1)) ? '0 : winner + 1'b1;
      end
   end

endmodule

// File: rtl/ft2232h_tx_scheduler.sv
// Arbitrates N capture channels onto one FT2232H sync-FIFO write port,
// sending header, channel ID and the frame MSB-first.
//   state | meaning
//   IDLE  | no frame in flight; grant on any request
//   HDR   | header byte on the bus, waiting for accept
//   CID   | channel-ID byte on the bus
//   PAY   | payload bytes, byte_cnt indexes the byte on the bus
module ft2232h_tx_scheduler
   import ft2232h_pkg::*;
#(
   parameter  int          N_CH           = 2,
   parameter  int          DATA_WIDTH     = 14,
   parameter  int          SAMPLES        = 40,
   parameter  logic [7:0]  HEADER_BYTE    = HEADER_BYTE_DEF,
   parameter  int          TIMEOUT_CYCLES = 65535,
   localparam int          FRAME_BITS     = DATA_WIDTH * SAMPLES
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_CH-1:0]              req,
   input  logic [N_CH*FRAME_BITS-1:0]   frame_data,
   output logic [N_CH-1:0]              gnt,
   input  logic                         txe_n,
   output logic                         wr_n,
   output logic [7:0]                   data_out,
   output logic                         busy,
   output logic                         abort_err
);

   localparam int BYTES    = frame_bytes(FRAME_BITS);
   localparam int SR_W     = BYTES * 8;
   localparam int PAD_BITS = SR_W - FRAME_BITS;
   localparam int CNT_W    = $clog2(BYTES + 1);
   localparam int ST_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int IW       = (N_CH > 1) ? $clog2(N_CH) : 1;

   tx_state_t             state;
   logic [SR_W-1:0]       sreg;
   logic [2:0]            ch_id;
   logic [CNT_W-1:0]      byte_cnt;
   logic [ST_W-1:0]       stall_cnt;
   logic [N_CH-1:0]       arb_gnt;
   logic [IW-1:0]         arb_winner;
   logic [FRAME_BITS-1:0] win_frame;
   logic                  arb_en;
   logic                  accept;

   assign arb_en = (state == IDLE) && (|req);
   assign accept = !wr_n && !txe_n;

   rr_arbiter #(.N(N_CH)) u_arb (
      .clk    (clk),
      .rst    (rst),
      .en     (arb_en),
      .req    (req),
      .gnt    (arb_gnt),
      .winner (arb_winner)
   );

   always_comb begin
      win_frame = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (arb_winner == IW'(i)) win_frame = frame_data[i*FRAME_BITS +: FRAME_BITS];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr_n      <= 1'b1;
         data_out  <= '0;
         gnt       <= '0;
         busy      <= 1'b0;
         abort_err <= 1'b0;
         sreg      <= '0;
         ch_id     <= '0;
         byte_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         gnt       <= '0;
         abort_err <= 1'b0;
         case (state)
            IDLE: begin
               stall_cnt <= '0;
               if (|req) begin
                  gnt      <= arb_gnt;
                  // Short frames are left-aligned so the last byte is zero-padded at its LSBs.
                  sreg     <= SR_W'(win_frame) << PAD_BITS;
                  ch_id    <= 3'(arb_winner);
                  data_out <= HEADER_BYTE;
                  wr_n     <= 1'b0;
                  busy     <= 1'b1;
                  state    <= HDR;
               end
            end
            default: begin
               if (accept) begin
                  stall_cnt <= '0;
                  case (state)
                     HDR: begin
                        data_out <= {5'b0, ch_id};
                        state    <= CID;
                     end
                     CID: begin
                        data_out <= sreg[SR_W-1 -: 8];
                        sreg     <= sreg << 8;
                        byte_cnt <= '0;
                        state    <= PAY;
                     end
                     PAY: begin
                        if (byte_cnt == CNT_W'(BYTES - 1)) begin
                           wr_n  <= 1'b1;
                           busy  <= 1'b0;
                           state <= IDLE;
                        end else begin
                           byte_cnt <= byte_cnt + 1'b1;
                           data_out <= sreg[SR_W-1 -: 8];
                           sreg     <= sreg << 8;
                        end
                     end
                     default: ;
                  endcase
               end else if (txe_n && (TIMEOUT_CYCLES != 0)) begin
                  // Abort on the edge that completes the TIMEOUT_CYCLES-th stall cycle.
                  if (stall_cnt == ST_W'(TIMEOUT_CYCLES - 1)) begin
                     wr_n      <= 1'b1;
                     busy      <= 1'b0;
                     abort_err <= 1'b1;
                     stall_cnt <= '0;
                     state     <= IDLE;
                  end else begin
                     stall_cnt <= stall_cnt + 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ft2232h_tx_scheduler.sv
// Directed bench: default config, a short-timeout config and a padded-frame config.
module tb_ft2232h_tx_scheduler;

   localparam int FB0   = 560;
   localparam int FB2   = 39;
   localparam int NXFER = 72;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst0, txe0, wr0, busy0, ab0;
   logic [1:0]       req0, gnt0;
   logic [2*FB0-1:0] fd0;
   logic [7:0]       d0;

   logic             rst1, txe1, wr1, busy1, ab1;
   logic [1:0]       req1, gnt1;
   logic [7:0]       d1;

   logic             rst2, txe2, wr2, busy2, ab2;
   logic [1:0]       req2, gnt2;
   logic [2*FB2-1:0] fd2;
   logic [7:0]       d2;

   ft2232h_tx_scheduler dut0 (
      .clk(clk), .rst(rst0), .req(req0), .frame_data(fd0), .gnt(gnt0), .txe_n(txe0),
      .wr_n(wr0), .data_out(d0), .busy(busy0), .abort_err(ab0));

   ft2232h_tx_scheduler #(.TIMEOUT_CYCLES(16)) dut1 (
      .clk(clk), .rst(rst1), .req(req1), .frame_data(fd0), .gnt(gnt1), .txe_n(txe1),
      .wr_n(wr1), .data_out(d1), .busy(busy1), .abort_err(ab1));

   ft2232h_tx_scheduler #(.DATA_WIDTH(13), .SAMPLES(3)) dut2 (
      .clk(clk), .rst(rst2), .req(req2), .frame_data(fd2), .gnt(gnt2), .txe_n(txe2),
      .wr_n(wr2), .data_out(d2), .busy(busy2), .abort_err(ab2));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Transfer idx: 0 header, 1 channel ID, 2.. payload (ch0 byte k = k+1, ch1 byte k = 0x80+k).
   function automatic logic [7:0] exp_byte(input int ch, input int idx);
      if (idx == 0) return 8'hFF;
      if (idx == 1) return 8'(ch);
      return (ch == 0) ? 8'(idx - 1) : 8'(8'h80 + idx - 2);
   endfunction

   task automatic run_frame(input int ch, input logic [1:0] req_after, input int stall_at,
                            input int stall_len, input int stop_idx, input int exp_wait);
      int idx, stalls, guard, waits;
      bit seen;
      idx = 0; stalls = 0; guard = 0; waits = 0; seen = 1'b0;
      while (idx < stop_idx && guard < 400) begin
         @(negedge clk);
         guard++;
         if (wr0) begin
            waits++;
            txe0 = 1'b0;
         end else begin
            if (!seen) begin
               seen = 1'b1;
               check("gnt", 32'(gnt0), 32'(1) << ch);
               check("busy_on", 32'(busy0), 32'd1);
               if (exp_wait >= 0) check("idle_gap", waits, exp_wait);
               req0 = req_after;
            end
            if (idx == 2 + stall_at && stalls < stall_len) begin
               txe0 = 1'b1;
               stalls++;
               check($sformatf("stall_hold%0d", idx), 32'(d0), 32'(exp_byte(ch, idx)));
            end else begin
               txe0 = 1'b0;
               check($sformatf("byte%0d", idx), 32'(d0), 32'(exp_byte(ch, idx)));
               idx++;
            end
         end
      end
      check("xfer_count", idx, stop_idx);
      if (stall_len > 0) check("stall_count", stalls, stall_len);
   endtask

   task automatic post_frame(input string tag);
      @(negedge clk);
      check({tag, "_wr_n"}, 32'(wr0), 32'd1);
      check({tag, "_busy"}, 32'(busy0), 32'd0);
      check({tag, "_gnt"},  32'(gnt0), 32'd0);
   endtask

   task automatic reset0();
      @(negedge clk);
      rst0 = 1'b1;
      @(negedge clk);
      rst0 = 1'b0;
   endtask

   logic [7:0] exp6 [7] = '{8'hFF, 8'h00, 8'h24, 8'h68, 8'hAC, 8'hF1, 8'h36};

   initial begin
      int g;
      rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
      txe0 = 1'b0; txe1 = 1'b0; txe2 = 1'b0;
      req0 = '0;   req1 = '0;   req2 = '0;
      fd0 = '0;
      for (int k = 0; k < 70; k++) begin
         fd0[FB0-1-8*k -: 8]     = 8'(k + 1);
         fd0[2*FB0-1-8*k -: 8]   = 8'(8'h80 + k);
      end
      fd2 = '0;
      fd2[FB2-1:0]     = 39'h12_3456_789B;
      fd2[2*FB2-1:FB2] = 39'h7F_FFFF_FFFF;

      repeat (3) @(negedge clk);
      check("rst_wr_n",  32'(wr0),   32'd1);
      check("rst_data",  32'(d0),    32'd0);
      check("rst_gnt",   32'(gnt0),  32'd0);
      check("rst_busy",  32'(busy0), 32'd0);
      check("rst_abort", 32'(ab0),   32'd0);
      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

      // single frame from ch0
      req0 = 2'b01;
      run_frame(0, 2'b00, 0, 0, NXFER, -1);
      post_frame("t1_end");
      @(negedge clk);
      check("t1_quiet", 32'(wr0), 32'd1);

      // contention with both requests held
      reset0();
      req0 = 2'b11;
      run_frame(0, 2'b11, 0, 0, NXFER, -1);
      post_frame("t2_a");
      run_frame(1, 2'b11, 0, 0, NXFER, 0);
      post_frame("t2_b");
      run_frame(0, 2'b00, 0, 0, NXFER, 0);
      post_frame("t2_c");

      // backpressure on payload byte 10
      req0 = 2'b01;
      run_frame(0, 2'b00, 10, 5, NXFER, -1);
      check("t3_no_abort", 32'(ab0), 32'd0);
      post_frame("t3_end");

      // reset at payload byte 30, then only ch1 requesting
      req0 = 2'b01;
      run_frame(0, 2'b00, 0, 0, 32, -1);
      @(negedge clk);
      check("t5_pre_byte", 32'(d0), 32'h1F);
      rst0 = 1'b1;
      @(negedge clk);
      check("t5_rst_wr_n", 32'(wr0),   32'd1);
      check("t5_rst_data", 32'(d0),    32'd0);
      check("t5_rst_busy", 32'(busy0), 32'd0);
      rst0 = 1'b0;
      req0 = 2'b10;
      run_frame(1, 2'b00, 0, 0, NXFER, 0);
      post_frame("t5_end");

      // pointer must return to 0 on reset even after a ch0 grant moved it to 1
      req0 = 2'b01;
      run_frame(0, 2'b00, 0, 0, 10, -1);
      reset0();
      req0 = 2'b11;
      run_frame(0, 2'b00, 0, 0, NXFER, 0);
      post_frame("t5b_end");

      // timeout with TIMEOUT_CYCLES=16, ch1 pending
      req1 = 2'b11;
      g = 0;
      do begin @(negedge clk); g++; end while (wr1 && g < 20);
      check("t4_gnt0", 32'(gnt1), 32'd1);
      check("t4_hdr",  32'(d1),   32'hFF);
      req1 = 2'b10;
      @(negedge clk);
      check("t4_id", 32'(d1), 32'h00);
      txe1 = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         check($sformatf("t4_abort%0d", i), 32'(ab1), (i == 16) ? 32'd1 : 32'd0);
         check($sformatf("t4_wr_n%0d", i),  32'(wr1), (i == 16) ? 32'd1 : 32'd0);
      end
      check("t4_busy", 32'(busy1), 32'd0);
      @(negedge clk);
      check("t4_gnt1",        32'(gnt1), 32'd2);
      check("t4_abort_pulse", 32'(ab1),  32'd0);
      check("t4_hdr2",        32'(d1),   32'hFF);
      req1 = 2'b00;

      // padded 39-bit frame
      req2 = 2'b01;
      g = 0;
      do begin @(negedge clk); g++; end while (wr2 && g < 20);
      check("t6_gnt", 32'(gnt2), 32'd1);
      req2 = 2'b00;
      for (int i = 0; i < 7; i++) begin
         if (i > 0) @(negedge clk);
         check($sformatf("t6_byte%0d", i), 32'(d2), 32'(exp6[i]));
         check($sformatf("t6_wr%0d", i),   32'(wr2), 32'd0);
      end
      @(negedge clk);
      check("t6_end_wr_n", 32'(wr2),   32'd1);
      check("t6_end_busy", 32'(busy2), 32'd0);
      check("t6_abort",    32'(ab2),   32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
